// File: rtl/mux_nw_rr_if.sv
// Handshake bundle between per-channel sources, the N:1 registered mux and its consumer.
// The master side drives the channel inputs and ready; the slave side is the mux itself.
interface mux_nw_rr_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 4
);
    localparam int unsigned SELW = $clog2(N);

    logic                 mode;
    logic [SELW-1:0]      s;
    logic [N*WIDTH-1:0]   d;
    logic [N-1:0]         v;
    logic [WIDTH-1:0]     y;
    logic                 y_valid;
    logic [SELW-1:0]      y_sel;
    logic                 y_ready;

    modport master (
        output mode, s, d, v, y_ready,
        input  y, y_valid, y_sel
    );

    modport slave (
        input  mode, s, d, v, y_ready,
        output y, y_valid, y_sel
    );
endinterface

// File: rtl/mux_nw_rr.sv
// N-channel registered multiplexer: manual select (mode 0) or round-robin over valid
// channels (mode 1), with a one-deep output register held under backpressure.
module mux_nw_rr #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 4
) (
    input  logic       clk,
    input  logic       rst,
    mux_nw_rr_if.slave bus
);
    localparam int unsigned SELW = $clog2(N);
    localparam int unsigned CNTW = SELW + 1;
    localparam int unsigned NP   = 1 << SELW;
    localparam logic [SELW-1:0] PTR_RST = SELW'(N - 1);

    logic [WIDTH-1:0] y_q,       y_d;
    logic             y_valid_q, y_valid_d;
    logic [SELW-1:0]  y_sel_q,   y_sel_d;
    logic [SELW-1:0]  ptr_q,     ptr_d;

    logic             load_c;
    logic             man_ok_c;
    logic             man_v_c;
    logic [WIDTH-1:0] man_d_c;
    logic             rr_hit_c;
    logic [SELW-1:0]  rr_idx_c;
    logic [WIDTH-1:0] rr_d_c;
    logic [CNTW-1:0]  cand_c;
    logic [NP-1:0]    v_pad_c;

    // Valid vector padded to a power of two so any SELW-bit index is in range.
    assign v_pad_c = NP'(bus.v);

    // Round-robin search starting just after the last grant; the last grant is tried last.
    always_comb begin
        rr_hit_c = 1'b0;
        rr_idx_c = '0;
        cand_c   = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            cand_c = CNTW'(ptr_q) + CNTW'(i);
            if (cand_c >= CNTW'(N)) begin
                cand_c = cand_c - CNTW'(N);
            end
            if (!rr_hit_c && v_pad_c[cand_c[SELW-1:0]]) begin
                rr_hit_c = 1'b1;
                rr_idx_c = cand_c[SELW-1:0];
            end
        end
    end

    // Channel decode for the manual select and for the round-robin winner.
    always_comb begin
        man_ok_c = 1'b0;
        man_v_c  = 1'b0;
        man_d_c  = '0;
        rr_d_c   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (bus.s == SELW'(k)) begin
                man_ok_c = 1'b1;
                man_v_c  = bus.v[k];
                man_d_c  = bus.d[k*WIDTH +: WIDTH];
            end
            if (rr_idx_c == SELW'(k)) begin
                rr_d_c = bus.d[k*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state: load when the output slot is empty or being consumed, else hold.
    always_comb begin
        y_d       = y_q;
        y_valid_d = y_valid_q;
        y_sel_d   = y_sel_q;
        ptr_d     = ptr_q;
        load_c    = !y_valid_q || bus.y_ready;
        if (load_c) begin
            if (!bus.mode) begin
                if (man_ok_c) begin
                    y_d       = man_d_c;
                    y_valid_d = man_v_c;
                    y_sel_d   = bus.s;
                end else begin
                    y_valid_d = 1'b0;
                end
            end else if (rr_hit_c) begin
                y_d       = rr_d_c;
                y_valid_d = 1'b1;
                y_sel_d   = rr_idx_c;
                ptr_d     = rr_idx_c;
            end else begin
                y_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q       <= '0;
            y_valid_q <= 1'b0;
            y_sel_q   <= '0;
            ptr_q     <= PTR_RST;
        end else begin
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            y_sel_q   <= y_sel_d;
            ptr_q     <= ptr_d;
        end
    end

    assign bus.y       = y_q;
    assign bus.y_valid = y_valid_q;
    assign bus.y_sel   = y_sel_q;

endmodule

// File: tb/tb_mux_nw_rr.sv
// Bench for mux_nw_rr: vector table and corner sequences on a 4x8 instance, wrap checks
// on a 3x4 instance, then random traffic on both against an arithmetic reference model.
module tb_mux_nw_rr;
    localparam int unsigned W4 = 8;
    localparam int unsigned N4 = 4;
    localparam int unsigned W3 = 4;
    localparam int unsigned N3 = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mux_nw_rr_if #(.WIDTH(W4), .N(N4)) bus4 ();
    mux_nw_rr_if #(.WIDTH(W3), .N(N3)) bus3 ();

    mux_nw_rr #(.WIDTH(W4), .N(N4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
    mux_nw_rr #(.WIDTH(W3), .N(N3)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit          mode;
        logic [1:0]  s;
        logic [31:0] d;
        logic [3:0]  v;
        bit          ready;
        logic [7:0]  y;
        bit          vld;
        logic [1:0]  sel;
    } vec_t;

    typedef struct {
        int y;
        bit vld;
        int sel;
        int ptr;
    } mstate_t;

    vec_t    vecs [19];
    mstate_t m4, m3;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic int chan(input logic [63:0] d, input int k, input int w);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        return int'((d >> (k * w)) & mask);
    endfunction

    // Reference: one clock of the mux expressed directly from the selection rules.
    function automatic mstate_t step(input mstate_t st, input int n, input int w, input bit mode,
                                     input int s, input logic [63:0] d, input logic [15:0] v,
                                     input bit ready);
        mstate_t r;
        bit found;
        int k;
        r = st;
        if (st.vld && !ready) return r;
        if (!mode) begin
            if (s < n) begin
                r.y   = chan(d, s, w);
                r.vld = v[s];
                r.sel = s;
            end else begin
                r.vld = 1'b0;
            end
        end else begin
            found = 1'b0;
            for (int j = 1; j <= n; j++) begin
                k = (st.ptr + j) % n;
                if (!found && v[k]) begin
                    found = 1'b1;
                    r.y   = chan(d, k, w);
                    r.vld = 1'b1;
                    r.sel = k;
                    r.ptr = k;
                end
            end
            if (!found) r.vld = 1'b0;
        end
        return r;
    endfunction

    task automatic drive4(input bit mode, input logic [1:0] s, input logic [31:0] d,
                          input logic [3:0] v, input bit ready);
        bus4.mode    = mode;
        bus4.s       = s;
        bus4.d       = d;
        bus4.v       = v;
        bus4.y_ready = ready;
    endtask

    task automatic drive3(input bit mode, input logic [1:0] s, input logic [11:0] d,
                          input logic [2:0] v, input bit ready);
        bus3.mode    = mode;
        bus3.s       = s;
        bus3.d       = d;
        bus3.v       = v;
        bus3.y_ready = ready;
    endtask

    task automatic expect4(input string name, input logic [7:0] y, input bit vld, input logic [1:0] sel);
        check({name, "_y"},   32'(bus4.y),       32'(y));
        check({name, "_vld"}, 32'(bus4.y_valid), 32'(vld));
        check({name, "_sel"}, 32'(bus4.y_sel),   32'(sel));
    endtask

    initial begin
        // Sequence from reset, pointer starts at 3. D bytes: ch0=11 ch1=22 ch2=33 ch3=44.
        vecs[0]  = '{1'b0, 2'd2, 32'h44332211, 4'hF,    1'b1, 8'h33, 1'b1, 2'd2};
        vecs[1]  = '{1'b0, 2'd0, 32'h44332211, 4'hF,    1'b1, 8'h11, 1'b1, 2'd0};
        vecs[2]  = '{1'b0, 2'd0, 32'h44332211, 4'hE,    1'b1, 8'h11, 1'b0, 2'd0};
        vecs[3]  = '{1'b1, 2'd0, 32'h44332211, 4'hF,    1'b1, 8'h11, 1'b1, 2'd0};
        vecs[4]  = '{1'b1, 2'd0, 32'h44332211, 4'hF,    1'b1, 8'h22, 1'b1, 2'd1};
        vecs[5]  = '{1'b1, 2'd0, 32'h44332211, 4'hF,    1'b1, 8'h33, 1'b1, 2'd2};
        vecs[6]  = '{1'b1, 2'd0, 32'h44332211, 4'hF,    1'b1, 8'h44, 1'b1, 2'd3};
        vecs[7]  = '{1'b1, 2'd0, 32'h44332211, 4'hF,    1'b1, 8'h11, 1'b1, 2'd0};
        vecs[8]  = '{1'b1, 2'd0, 32'h44332211, 4'b1010, 1'b1, 8'h22, 1'b1, 2'd1};
        vecs[9]  = '{1'b1, 2'd0, 32'h44332211, 4'b1010, 1'b1, 8'h44, 1'b1, 2'd3};
        vecs[10] = '{1'b1, 2'd0, 32'h44332211, 4'b1010, 1'b1, 8'h22, 1'b1, 2'd1};
        vecs[11] = '{1'b1, 2'd0, 32'h44332211, 4'b1010, 1'b1, 8'h44, 1'b1, 2'd3};
        vecs[12] = '{1'b1, 2'd0, 32'h44332211, 4'b0000, 1'b1, 8'h44, 1'b0, 2'd3};
        vecs[13] = '{1'b1, 2'd0, 32'h44332211, 4'b0001, 1'b1, 8'h11, 1'b1, 2'd0};
        vecs[14] = '{1'b1, 2'd0, 32'hAABBCCDD, 4'hF,    1'b0, 8'h11, 1'b1, 2'd0};
        vecs[15] = '{1'b1, 2'd0, 32'h44332211, 4'hF,    1'b1, 8'h22, 1'b1, 2'd1};
        vecs[16] = '{1'b0, 2'd3, 32'h44332211, 4'b0111, 1'b1, 8'h44, 1'b0, 2'd3};
        vecs[17] = '{1'b0, 2'd1, 32'h44332211, 4'b0111, 1'b0, 8'h22, 1'b1, 2'd1};
        vecs[18] = '{1'b1, 2'd0, 32'h44332211, 4'hF,    1'b1, 8'h33, 1'b1, 2'd2};

        rst = 1'b1;
        drive4(1'b0, 2'd0, 32'h0, 4'h0, 1'b1);
        drive3(1'b0, 2'd0, 12'h0, 3'h0, 1'b1);
        #1;
        expect4("reset", 8'h00, 1'b0, 2'd0);
        check("reset3_vld", 32'(bus3.y_valid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            drive4(vecs[i].mode, vecs[i].s, vecs[i].d, vecs[i].v, vecs[i].ready);
            cycle();
            expect4($sformatf("vec%0d", i), vecs[i].y, vecs[i].vld, vecs[i].sel);
        end

        // Asynchronous reset mid-cycle with a valid word in the register.
        drive4(1'b0, 2'd2, 32'h44332211, 4'hF, 1'b0);
        cycle();
        expect4("t1_pre", 8'h33, 1'b1, 2'd2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        expect4("t1_async", 8'h00, 1'b0, 2'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Backpressure: grant held for three stalled cycles, then no channel skipped.
        drive4(1'b1, 2'd0, 32'h44332211, 4'hF, 1'b1);
        cycle();
        expect4("t5_g0", 8'h11, 1'b1, 2'd0);
        cycle();
        expect4("t5_g1", 8'h22, 1'b1, 2'd1);
        for (int i = 0; i < 3; i++) begin
            drive4(1'b1, 2'($urandom()), $urandom(), 4'($urandom()), 1'b0);
            cycle();
            expect4($sformatf("t5_stall%0d", i), 8'h22, 1'b1, 2'd1);
        end
        drive4(1'b1, 2'd0, 32'h44332211, 4'hF, 1'b1);
        cycle();
        expect4("t5_resume", 8'h33, 1'b1, 2'd2);

        // Non-power-of-two instance: out-of-range select and wrap at 3.
        do_reset();
        drive3(1'b0, 2'd3, 12'h321, 3'b111, 1'b1);
        cycle();
        check("t6_s3_vld", 32'(bus3.y_valid), 32'd0);
        check("t6_s3_sel", 32'(bus3.y_sel), 32'd0);
        drive3(1'b1, 2'd0, 12'h321, 3'b111, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cycle();
            check($sformatf("t6_rr%0d_sel", i), 32'(bus3.y_sel), 32'(i % 3));
            check($sformatf("t6_rr%0d_y", i), 32'(bus3.y), 32'((i % 3) + 1));
        end

        // Random traffic on both instances against the reference model.
        do_reset();
        m4 = '{0, 1'b0, 0, 3};
        m3 = '{0, 1'b0, 0, 2};
        for (int it = 0; it < 400; it++) begin
            drive4(($urandom_range(0, 3) != 0), 2'($urandom()), $urandom(), 4'($urandom()),
                   ($urandom_range(0, 9) < 7));
            drive3(($urandom_range(0, 3) != 0), 2'($urandom()), 12'($urandom()), 3'($urandom()),
                   ($urandom_range(0, 9) < 7));
            m4 = step(m4, 4, 8, bus4.mode, int'(bus4.s), 64'(bus4.d), 16'(bus4.v), bus4.y_ready);
            m3 = step(m3, 3, 4, bus3.mode, int'(bus3.s), 64'(bus3.d), 16'(bus3.v), bus3.y_ready);
            cycle();
            check($sformatf("rnd4_%0d_vld", it), 32'(bus4.y_valid), 32'(m4.vld));
            check($sformatf("rnd4_%0d_y",   it), 32'(bus4.y),       32'(m4.y));
            check($sformatf("rnd4_%0d_sel", it), 32'(bus4.y_sel),   32'(m4.sel));
            check($sformatf("rnd3_%0d_vld", it), 32'(bus3.y_valid), 32'(m3.vld));
            check($sformatf("rnd3_%0d_y",   it), 32'(bus3.y),       32'(m3.y));
            check($sformatf("rnd3_%0d_sel", it), 32'(bus3.y_sel),   32'(m3.sel));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
